inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction-fetch controller that sequences the asynchronous, word-indexed instruction ROM on behalf of the CPU front end. It owns the fetch PC, prefetches up to DEPTH instructions into a small queue, and hands them to decode over a valid/ready handshake. It flushes and refetches on a branch or jump redirect. It also arbitrates a single debug/loader read port onto the same ROM address bus; debug has priority over fetch.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rom_addr  out  10  word address to the ROM.
- rom_inst  in  32  ROM data, combinational from rom_addr.
- out_valid  out  1  head of the queue is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  32  byte PC of the head instruction.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new byte PC; bits [1:0] ignored and forced to 0.
- dbg_req  in  1  debug read request.
- dbg_addr  in  10  debug word address.
- dbg_ack  out  1  debug read served this cycle (combinational).
- dbg_data  out  32  ROM word for dbg_addr, valid when dbg_ack=1.

## Operation
- State: fetch_pc[31:0], a queue of DEPTH {pc, inst} entries, rd_ptr/wr_ptr (log2 DEPTH bits, wrap naturally), and count (0..DEPTH).
- ROM address mux:
  - dbg_req=1 gives rom_addr=dbg_addr, dbg_ack=1 and dbg_data=rom_inst in the same cycle.
  - Otherwise rom_addr=fetch_pc[11:2], dbg_ack=0 and dbg_data=0.
- Pop: pop = out_valid & out_ready & ~redirect_valid.
- Push: push = ~dbg_req & ~redirect_valid & (count<DEPTH | pop). A push writes {fetch_pc, rom_inst} at wr_ptr and advances fetch_pc by 4.
- fetch_pc wraps mod 2^32. The ROM index therefore wraps every 4 KiB, because only bits [11:2] reach the ROM.
- A push and a pop in the same cycle leave count unchanged; this is legal while the queue is full.
- Redirect (highest priority for queue state):
  - count, rd_ptr and wr_ptr are cleared, and fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No push occurs, and any handshake in that cycle is discarded: decode must treat an instruction shown during a redirect cycle as not consumed.
- Redirect together with dbg_req: both take effect (debug is served, the flush happens).
- dbg_req stalls fetch only. The queue keeps draining to decode.
- out_valid = (count!=0). out_inst and out_pc come from the entry at rd_ptr, read from registered storage with no path from rom_inst.
- Reset clears all storage. While rst=1: fetch_pc=RESET_PC, count=0, out_valid=0, out_inst=0, out_pc=0, dbg_ack follows dbg_req, rom_addr=dbg_req?dbg_addr:RESET_PC[11:2].
- Reset asserted mid-operation discards every queued entry immediately (asynchronously).

## Timing
- Fetch latency: an entry is pushed at edge E, and out_valid rises right after E.
  - After rst falls, out_valid is first 1 after the first rising edge.
  - After a redirect sampled at edge N, the redirect_pc entry is pushed at edge N+1, so out_valid=0 for exactly one cycle between those edges.
- Throughput: 1 instruction/cycle sustained while out_ready=1 and dbg_req=0.
- Debug: zero-cycle response, no wait states. Each cycle with dbg_req=1 costs fetch exactly one push slot.
- Outputs out_* change only on clock edges or on reset. dbg_ack and dbg_data are combinational.

## Structure
- Shared package inst_fetch_pkg: DEPTH default, ROM_AW=10, the fetch entry typedef {pc[31:0], inst[31:0]}, and RESET_PC default.
- Sub-module fetch_fifo: a synchronous FIFO with push, pop, synchronous flush, async reset, count and head outputs. inst_fetch_ctrl contains the PC, the arbitration mux and the push/pop logic.

## Test plan
- ROM model with word i = 32'h1000_0000+i; out_ready=1 after reset. Expect out_pc = 0,4,8,… and out_inst = 1000_0000, 1000_0001,… on consecutive cycles with no bubbles.
- Hold out_ready=0 for 10 cycles. Expect count saturates at 4, fetch_pc=0x10, and pc 0..0xC are then delivered in order. The full+pop cycle pushes pc 0x10 without a bubble.
- Redirect to 0x0000_0043 with 3 entries queued. Expect one cycle out_valid=0, then out_pc=0x40 and out_inst=1000_0010. No stale entry appears.
- dbg_req=1 with dbg_addr=5 for 3 cycles during streaming. Expect dbg_ack=1 and dbg_data=1000_0005 each cycle, no pushes, the queue drains, and fetch resumes at the same PC.
- Redirect to 0xFFFF_FFFC. Expect out_pc=FFFF_FFFC with rom index 0x3FF, then out_pc=0000_0000 with index 0.
- Assert rst for half a cycle mid-stream. Expect out_valid=0 immediately, then a restart at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
//   DEPTH_DEF    : default prefetch queue depth
//   ROM_AW       : ROM word-address width
//   RESET_PC_DEF : default fetch PC after reset
//   fetch_entry_t: one queued instruction {pc, inst}
package inst_fetch_pkg;

  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned ROM_AW       = 10;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with synchronous flush and async reset.
//   clk, rst : clock, async active-high reset (clears storage)
//   flush    : clear pointers and count; overrides push/pop
//   push/din : write din at the tail
//   pop      : drop the head
//   count    : number of valid entries (0..DEPTH)
//   head     : entry at the read pointer, straight from registers
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  din,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop_ok;
  logic          push_ok;

  // Pop only when occupied; push into a full queue only alongside a pop.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (!push_ok && pop_ok) count <= count - CW'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_ok && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, prefetches from the
// combinational ROM into a small queue and hands instructions to decode.
// A debug read port shares the ROM address bus and has priority over fetch.
//   clk, rst          : clock, async active-high reset
//   rom_addr/rom_inst : ROM word address out, instruction word in
//   out_valid/ready   : decode handshake; out_inst/out_pc are the head entry
//   redirect_valid/pc : flush the queue and refetch from redirect_pc
//   dbg_req/addr      : debug ROM read; dbg_ack/dbg_data answer same cycle
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              dbg_req,
  input  logic [ROM_AW-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [31:0]       dbg_data
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          pop;
  logic          push;

  // ROM address arbitration: debug wins, fetch stalls for that cycle.
  assign rom_addr = dbg_req ? dbg_addr : fetch_pc[ROM_AW+1:2];
  assign dbg_ack  = dbg_req;
  assign dbg_data = dbg_req ? rom_inst : 32'h0;

  // A redirect cycle discards the handshake and blocks the push.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = !dbg_req && !redirect_valid && ((count < CW'(DEPTH)) || pop);

  assign push_entry.pc   = fetch_pc;
  assign push_entry.inst = rom_inst;

  assign out_inst = head.inst;
  assign out_pc   = head.pc;

  // Fetch PC: redirect target (word aligned) or sequential advance per push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dbg_req;
  logic [9:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // ROM model: word i holds 0x1000_0000 + i.
  assign rom_inst = 32'h1000_0000 + {22'h0, rom_addr};

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_ack        (dbg_ack),
    .dbg_data       (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dbg_req        = 1'b0;
    dbg_addr       = 10'h0;

    // Reset values and debug port while in reset.
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    dbg_req = 1'b1; dbg_addr = 10'd7;
    #1;
    check("rst_dbg_addr", 32'(rom_addr), 32'd7);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd1);
    check("rst_dbg_data", dbg_data, 32'h1000_0007);
    dbg_req = 1'b0;
    #1;
    check("rst_dbg_ack_off", 32'(dbg_ack), 32'd0);
    check("rst_dbg_data_off", dbg_data, 32'h0);
    @(negedge clk);
    check("rst_valid2", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1;

    // Streaming: one instruction per cycle, no bubbles.
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc", out_pc, 32'(4 * (k - 1)));
      check("stream_inst", out_inst, 32'h1000_0000 + 32'(k - 1));
    end

    // Fresh start, then decode stalls for 10 cycles.
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0;
    #1;
    check("rst2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_pc", out_pc, 32'h0);
      if (k == 2)  check("stall_rom_addr2", 32'(rom_addr), 32'd2);
      if (k == 10) check("stall_rom_addr_sat", 32'(rom_addr), 32'd4);
    end
    out_ready = 1'b1;
    // Full+pop pushes 0x10 in the same cycle; delivery stays gap-free.
    for (int k = 11; k <= 15; k++) begin
      @(negedge clk);
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_pc", out_pc, 32'(4 * (k - 10)));
      check("drain_inst", out_inst, 32'h1000_0000 + 32'(k - 10));
      if (k == 11) check("full_pop_push", 32'(rom_addr), 32'd5);
    end

    // One debug cycle drops the queue to 3 entries (0x18, 0x1C, 0x20).
    dbg_req = 1'b1; dbg_addr = 10'd9;
    #1;
    check("dbg1_data", dbg_data, 32'h1000_0009);
    @(negedge clk);
    check("pre_redir_pc", out_pc, 32'h18);
    dbg_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir_bubble", 32'(out_valid), 32'd0);
    check("redir_rom_addr", 32'(rom_addr), 32'h10);
    @(negedge clk);
    check("redir_valid", 32'(out_valid), 32'd1);
    check("redir_pc", out_pc, 32'h40);
    check("redir_inst", out_inst, 32'h1000_0010);
    @(negedge clk);
    check("redir_next_pc", out_pc, 32'h44);
    check("redir_next_inst", out_inst, 32'h1000_0011);

    // Debug for 3 cycles: served immediately, queue drains, fetch frozen at 0x48.
    for (int k = 0; k < 3; k++) begin
      dbg_req = 1'b1; dbg_addr = 10'd5;
      #1;
      check("dbg_ack", 32'(dbg_ack), 32'd1);
      check("dbg_data", dbg_data, 32'h1000_0005);
      check("dbg_rom_addr", 32'(rom_addr), 32'd5);
      @(negedge clk);
      check("dbg_drained", 32'(out_valid), 32'd0);
    end
    dbg_req = 1'b0;
    #1;
    check("dbg_resume_addr", 32'(rom_addr), 32'h12);
    @(negedge clk);
    check("dbg_resume_pc", out_pc, 32'h48);
    check("dbg_resume_inst", out_inst, 32'h1000_0012);

    // Redirect to the top of the address space; PC and ROM index wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("wrap_bubble", 32'(out_valid), 32'd0);
    check("wrap_rom_addr", 32'(rom_addr), 32'h3FF);
    @(negedge clk);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_inst", out_inst, 32'h1000_03FF);
    check("wrap_rom_addr0", 32'(rom_addr), 32'h0);
    @(negedge clk);
    check("wrap_pc0", out_pc, 32'h0);
    check("wrap_inst0", out_inst, 32'h1000_0000);

    // Half-cycle asynchronous reset mid-stream.
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_pc", out_pc, 32'h0);
    check("async_rst_inst", out_inst, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("restart_idle", 32'(out_valid), 32'd0);
    check("restart_rom_addr", 32'(rom_addr), 32'h0);
    @(negedge clk);
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_pc", out_pc, 32'h0);
    check("restart_inst", out_inst, 32'h1000_0000);
    @(negedge clk);
    check("restart_pc1", out_pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net; the directed sequence ends long before this.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
